pci_initiator_seq: RTL

//  Initiator-side bus-cycle sequencer for the PCI-style bus checked by the data_end_rule properties.

---
 rtl/pci_initiator_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pci_initiator_seq.sv
`default_nettype none
// ============================================================================
// Module      : pci_initiator_seq
// Description : Initiator-side bus-cycle sequencer for a PCI-style bus.
//               Drives the active-low frame_n/irdy_n handshake through an
//               address phase and a burst of data phases counted on trdy_n.
//               Terminates on burst completion, target stop_n (disconnect or
//               retry) or master timeout, then retires the cycle so that
//               frame_n rises one cycle after the data end and irdy_n one
//               cycle after that.
// Ports       : mclk        - bus clock, all logic on posedge
//               rst         - asynchronous active-high reset
//               start       - burst request, sampled only in IDLE
//               burst_len   - data phases in the burst (0 => start ignored)
//               trdy_n      - target ready, active low
//               stop_n      - target stop, active low
//               frame_n     - bus frame, active low, registered
//               irdy_n      - initiator ready, active low, registered
//               data_phase  - high while in DATA
//               busy        - high in any state other than IDLE
//               data_ack    - one-cycle pulse per completed data phase
//               done        - one-cycle pulse on return to IDLE
//               status      - 00 ok, 01 disconnect, 10 retry, 11 master abort
//               xfer_count  - data phases completed in current/last burst
// Revision    : 1.0 - initial release
// ============================================================================
module pci_initiator_seq #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             trdy_n,
  input  logic             stop_n,
  output logic             frame_n,
  output logic             irdy_n,
  output logic             data_phase,
  output logic             busy,
  output logic             data_ack,
  output logic             done,
  output logic [1:0]       status,
  output logic [LEN_W-1:0] xfer_count
);

  localparam int c_TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] c_ST_OK    = 2'b00;
  localparam logic [1:0] c_ST_DISC  = 2'b01;
  localparam logic [1:0] c_ST_RETRY = 2'b10;
  localparam logic [1:0] c_ST_ABORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_FIN1 = 3'd3,
    S_FIN2 = 3'd4,
    S_TURN = 3'd5
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [c_TO_W-1:0] r_tmo;

  logic [LEN_W:0]   w_cnt_inc;
  logic             w_last;
  logic             w_tmo_hit;

  // Compare one bit wider so a full-length burst cannot alias through wrap.
  assign w_cnt_inc = {1'b0, xfer_count} + {{LEN_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, r_len});
  assign w_tmo_hit = (r_tmo == c_TO_W'(TIMEOUT - 1));

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_tmo      <= '0;
      frame_n    <= 1'b1;
      irdy_n     <= 1'b1;
      data_phase <= 1'b0;
      busy       <= 1'b0;
      data_ack   <= 1'b0;
      done       <= 1'b0;
      status     <= c_ST_OK;
      xfer_count <= '0;
    end else begin
      data_ack <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (burst_len != '0)) begin
            r_state    <= S_ADDR;
            r_len      <= burst_len;
            xfer_count <= '0;
            status     <= c_ST_OK;
            frame_n    <= 1'b0;
            irdy_n     <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_ADDR: begin
          r_state    <= S_DATA;
          irdy_n     <= 1'b0;
          data_phase <= 1'b1;
          r_tmo      <= '0;
        end
        S_DATA: begin
          if (!trdy_n) begin
            data_ack <= 1'b1;
            r_tmo    <= '0;
            if (xfer_count != r_len) begin
              xfer_count <= xfer_count + 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
          // Termination priority: completion beats a simultaneous stop;
          // a stop with no data moved yet is a retry, otherwise a disconnect.
          if (!trdy_n && w_last) begin
            r_state    <= S_FIN1;
            frame_n    <= 1'b1;
            data_phase <= 1'b0;
            status     <= c_ST_OK;
          end else if (!stop_n) begin
            r_state    <= S_FIN1;
            frame_n    <= 1'b1;
            data_phase <= 1'b0;
            if (trdy_n && (xfer_count == '0)) begin
              status <= c_ST_RETRY;
            end else begin
              status <= c_ST_DISC;
            end
          end else if (trdy_n && w_tmo_hit) begin
            r_state    <= S_FIN1;
            frame_n    <= 1'b1;
            data_phase <= 1'b0;
            status     <= c_ST_ABORT;
          end
        end
        S_FIN1: begin
          r_state <= S_FIN2;
          irdy_n  <= 1'b1;
        end
        S_FIN2: begin
          r_state <= S_TURN;
        end
        S_TURN: begin
          r_state <= S_IDLE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          frame_n    <= 1'b1;
          irdy_n     <= 1'b1;
          data_phase <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
